// File: rtl/isp_vid_switch.sv
// Glitch-free video input switch: changes source only when both old and new channels are blanked.
// Optional forced-switch timeout is built when ISP_VID_SWITCH_TIMEOUT_EN is defined.
module isp_vid_switch #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DELAY    = 0,
  parameter int unsigned TIMEOUT  = 4096,
  localparam int unsigned SW      = $clog2(CHANNELS)
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [SW-1:0]            sel_req,
  input  logic [CHANNELS-1:0]      in_href,
  input  logic [CHANNELS-1:0]      in_vsync,
  input  logic [CHANNELS*BITS-1:0] in_data,
  output logic                     out_href,
  output logic                     out_vsync,
  output logic [BITS-1:0]          out_data,
  output logic [SW-1:0]            sel_active,
  output logic                     switch_pending,
  output logic                     timeout_err
);

  typedef enum logic {StStable, StPending} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] active_q, active_d;
  logic [SW-1:0] target_q, target_d;

  logic req_valid, both_blank, cancel, retarget, timeout_hit;

  assign req_valid  = 32'(sel_req) < CHANNELS;
  assign both_blank = !in_href[active_q] && !in_vsync[active_q] &&
                      !in_href[target_q] && !in_vsync[target_q];
  assign cancel     = req_valid && (sel_req == active_q);
  assign retarget   = req_valid && (sel_req != active_q) && (sel_req != target_q);

  // Pending resolution priority: cancel, retarget, blank switch, forced switch.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    target_d = target_q;
    case (state_q)
      StStable: begin
        if (req_valid && (sel_req != active_q)) begin
          target_d = sel_req;
          state_d  = StPending;
        end
      end
      StPending: begin
        if (cancel) begin
          state_d = StStable;
        end else if (retarget) begin
          target_d = sel_req;
        end else if (both_blank || timeout_hit) begin
          active_d = target_q;
          state_d  = StStable;
        end
      end
      default: state_d = StStable;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= StStable;
      active_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      target_q <= target_d;
    end
  end

`ifdef ISP_VID_SWITCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          forced;

  assign timeout_hit = cnt_q >= CW'(TIMEOUT - 1);
  assign forced      = (state_q == StPending) && !cancel && !retarget && !both_blank &&
                       timeout_hit;

  always_comb begin
    cnt_d = '0;
    if ((state_q == StPending) && (state_d == StPending) && !retarget) begin
      cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
    err_d = err_q | forced;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Stage 0 samples the channel selected before this edge; DELAY stages follow.
  logic [BITS+1:0] pipe_q [DELAY+1];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i <= int'(DELAY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {in_href[active_q], in_vsync[active_q], in_data[active_q*BITS +: BITS]};
      for (int i = 1; i <= int'(DELAY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign {out_href, out_vsync, out_data} = pipe_q[DELAY];
  assign sel_active     = active_q;
  assign switch_pending = (state_q == StPending);

endmodule
